// File: rtl/vnu_serial_accum.sv
// Serial variable-node accumulator: takes a channel LLR plus DV messages in two's complement,
// then emits the hard decision and DV saturated sign-magnitude extrinsic messages.
module vnu_serial_accum #(
   parameter int DATA_WIDTH = 5,
   parameter int DV         = 3,
   parameter int SUM_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] ch_llr,
   input  logic                  msg_valid,
   input  logic [DATA_WIDTH-1:0] msg_in,
   output logic                  msg_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_msg,
   output logic                  dec_valid,
   output logic                  dec_bit,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = (DV > 1) ? $clog2(DV) : 1;
   localparam int DW = SUM_WIDTH + 1;
   localparam logic signed [DW-1:0] MAXV = DW'((1 << (DATA_WIDTH - 1)) - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

   state_t                        r_state;
   logic [CW-1:0]                 r_cnt;
   logic [CW-1:0]                 r_idx;
   logic signed [SUM_WIDTH-1:0]   r_acc;
   logic signed [DATA_WIDTH-1:0]  r_buf [DV];
   logic                          r_dec_valid;
   logic                          r_dec_bit;
   logic                          r_done;

   logic signed [SUM_WIDTH-1:0]   w_msg_ext;
   logic signed [SUM_WIDTH-1:0]   w_acc_next;
   logic signed [DW-1:0]          w_diff;
   logic signed [DW-1:0]          w_sat;
   logic signed [DW-1:0]          w_abs;
   logic                          w_neg;
   logic [DATA_WIDTH-1:0]         w_sm;

   assign w_msg_ext  = SUM_WIDTH'($signed(msg_in));
   assign w_acc_next = r_acc + w_msg_ext;

   // Extrinsic = total minus own message, widened by one bit so the subtraction cannot wrap.
   always_comb begin
      w_diff = DW'(r_acc) - DW'(r_buf[r_idx]);
      w_sat  = w_diff;
      if (w_diff > MAXV) begin
         w_sat = MAXV;
      end else if (w_diff < -MAXV) begin
         w_sat = -MAXV;
      end
      w_neg = w_sat[DW-1];
      w_abs = w_neg ? -w_sat : w_sat;
      w_sm  = {w_neg, w_abs[DATA_WIDTH-2:0]};
   end

   assign msg_ready = (r_state == S_ACCUM);
   assign out_valid = (r_state == S_EMIT);
   assign busy      = (r_state != S_IDLE);
   assign out_msg   = out_valid ? w_sm : '0;
   assign dec_valid = r_dec_valid;
   assign dec_bit   = r_dec_bit;
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_dec_valid <= 1'b0;
         r_dec_bit   <= 1'b0;
         r_done      <= 1'b0;
         for (int i = 0; i < DV; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         r_dec_valid <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc   <= SUM_WIDTH'($signed(ch_llr));
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (msg_valid) begin
                  r_buf[r_cnt] <= $signed(msg_in);
                  r_acc        <= w_acc_next;
                  if (r_cnt == CW'(DV - 1)) begin
                     r_cnt       <= '0;
                     r_state     <= S_EMIT;
                     r_dec_valid <= 1'b1;
                     r_dec_bit   <= w_acc_next[SUM_WIDTH-1];
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  if (r_idx == CW'(DV - 1)) begin
                     r_idx   <= '0;
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx <= r_idx + CW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vnu_serial_accum.sv
// Scoreboard bench for vnu_serial_accum: directed test-plan frames plus randomized frames,
// expected decisions/extrinsics computed from plain integer arithmetic.
module tb_vnu_serial_accum;

   localparam int W  = 5;
   localparam int DV = 3;
   localparam int SW = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] ch_llr = '0;
   logic         msg_valid = 1'b0;
   logic [W-1:0] msg_in = '0;
   logic         msg_ready;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_msg;
   logic         dec_valid;
   logic         dec_bit;
   logic         busy;
   logic         done;

   vnu_serial_accum #(.DATA_WIDTH(W), .DV(DV), .SUM_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .ch_llr(ch_llr),
      .msg_valid(msg_valid), .msg_in(msg_in), .msg_ready(msg_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
      .dec_valid(dec_valid), .dec_bit(dec_bit), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_out[$];
   int exp_dec[$];
   int hs = 0;
   int frames_exp = 0;
   int frames_done = 0;
   bit stall_req = 1'b0;
   bit bp_rand = 1'b0;
   int stall_cnt = 0;
   bit prev_stall = 1'b0;
   logic [W-1:0] prev_msg = '0;

   function automatic void check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Saturate to +/-(2^(W-1)-1) and encode as sign-magnitude.
   function automatic int sm_enc(int v);
      int lim = (1 << (W - 1)) - 1;
      if (v > lim) v = lim;
      if (v < -lim) v = -lim;
      return (v < 0) ? ((1 << (W - 1)) | -v) : v;
   endfunction

   function automatic void push_frame(int ch, int m0, int m1, int m2);
      int total = ch + m0 + m1 + m2;
      exp_dec.push_back((total < 0) ? 1 : 0);
      exp_out.push_back(sm_enc(total - m0));
      exp_out.push_back(sm_enc(total - m1));
      exp_out.push_back(sm_enc(total - m2));
      frames_exp++;
   endfunction

   // Monitor: compares every decision pulse and output handshake against the queues.
   always @(negedge clk) begin
      if (rst) begin
         hs = 0;
         prev_stall = 1'b0;
      end else begin
         if (dec_valid) begin
            if (exp_dec.size() == 0) check("unexpected_dec", 1, 0);
            else check("dec_bit", int'(dec_bit), exp_dec.pop_front());
         end
         if (prev_stall) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_msg", int'(out_msg), int'(prev_msg));
         end
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) check("unexpected_out", 1, 0);
            else check("out_msg", int'(out_msg), exp_out.pop_front());
            hs++;
         end
         prev_stall = out_valid && !out_ready;
         prev_msg = out_msg;
         if (done) begin
            check("done_after_handshakes", hs, DV);
            hs = 0;
            frames_done++;
         end
      end
   end

   // out_ready driver: directed 3-cycle stall at the second output, or random backpressure.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
         end else if (stall_req && hs == 1 && out_valid) begin
            out_ready = 1'b0;
            stall_cnt = 2;
            stall_req = 1'b0;
         end else begin
            out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) check("idle_timeout", 1, 0);
   endtask

   task automatic drive_frame(input int ch, input int m0, input int m1, input int m2,
                              input bit gaps, input bit noise, input int abort_after,
                              input bit stall);
      int m[3];
      int k;
      m[0] = m0; m[1] = m1; m[2] = m2;
      wait_idle();
      #1;
      if (noise) begin
         msg_valid = 1'b1;
         msg_in = W'($urandom);
         @(negedge clk);
         #1;
         msg_valid = 1'b0;
      end
      if (abort_after < 0) push_frame(ch, m0, m1, m2);
      stall_req = stall;
      start = 1'b1;
      ch_llr = W'(ch);
      @(negedge clk);
      #1;
      start = 1'b0;
      ch_llr = W'($urandom);
      for (int i = 0; i < DV; i++) begin
         if (i == abort_after) begin
            msg_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            check("abort_msg_ready", int'(msg_ready), 0);
            check("abort_busy", int'(busy), 0);
            check("abort_out_valid", int'(out_valid), 0);
            check("abort_out_msg", int'(out_msg), 0);
            check("abort_dec_valid", int'(dec_valid), 0);
            check("abort_dec_bit", int'(dec_bit), 0);
            check("abort_done", int'(done), 0);
            #1;
            rst = 1'b0;
            return;
         end
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               msg_valid = 1'b0;
               msg_in = W'($urandom);
               @(negedge clk);
               #1;
            end
         end
         msg_valid = 1'b1;
         msg_in = W'(m[i]);
         k = 0;
         while (!msg_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
         end
         if (k >= 50) check("msg_ready_timeout", 0, 1);
         @(negedge clk);
         #1;
      end
      msg_valid = 1'b0;
      if (noise) begin
         k = 0;
         while (!out_valid && k < 50) begin
            @(negedge clk);
            #1;
            k++;
         end
         if (k >= 50) check("out_valid_timeout", 0, 1);
         start = 1'b1;
         ch_llr = W'($urandom);
         msg_valid = 1'b1;
         msg_in = W'($urandom);
         @(negedge clk);
         #1;
         start = 1'b0;
         msg_valid = 1'b0;
      end
   endtask

   function automatic int rnd_val();
      return int'($urandom_range(0, 31)) - 16;
   endfunction

   initial begin
      int k;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_msg_ready", int'(msg_ready), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_msg", int'(out_msg), 0);
      check("reset_dec_valid", int'(dec_valid), 0);
      check("reset_dec_bit", int'(dec_bit), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      #1;
      rst = 1'b0;

      drive_frame(4, 3, -2, 5, 1'b0, 1'b0, -1, 1'b0);
      drive_frame(15, 15, 15, 15, 1'b0, 1'b0, -1, 1'b0);
      drive_frame(-15, -15, -15, -1, 1'b0, 1'b0, -1, 1'b0);
      drive_frame(0, 2, -2, 0, 1'b0, 1'b0, -1, 1'b0);
      drive_frame(4, 3, -2, 5, 1'b0, 1'b0, -1, 1'b1);
      drive_frame(4, 3, -2, 5, 1'b0, 1'b0, 2, 1'b0);
      drive_frame(4, 3, -2, 5, 1'b0, 1'b0, -1, 1'b0);
      drive_frame(-16, -16, -16, -16, 1'b1, 1'b1, -1, 1'b0);
      drive_frame(7, -16, 9, 0, 1'b1, 1'b1, -1, 1'b0);

      bp_rand = 1'b1;
      repeat (40) begin
         drive_frame(rnd_val(), rnd_val(), rnd_val(), rnd_val(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
      end

      wait_idle();
      k = 0;
      while ((exp_out.size() != 0 || frames_done != frames_exp) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("exp_out_left", exp_out.size(), 0);
      check("exp_dec_left", exp_dec.size(), 0);
      check("frames_done", frames_done, frames_exp);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

endmodule
